// File: rtl/bus_dev_port.sv
// bus_dev_port: device-side bus endpoint.
// TX FIFO (local writer -> arbiter via pndng/pop/D_pop) and
// RX FIFO (arbiter push/D_push -> local reader), both first-word fall-through.
// Optional destination filter on the RX path: define BUS_DEV_ADDR_CHECK_EN.
module bus_dev_port #(
  parameter int          pckg_sz = 16,
  parameter int          depth   = 8,
  parameter int          id      = 0,
  parameter logic [7:0]  bdcst   = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               tx_valid,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_ready,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  input  logic               rx_ready,
  output logic               tx_err,
  output logic               rx_ovf,
  output logic [7:0]         rx_drop_cnt
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  // ---------------- TX FIFO state ----------------
  logic [pckg_sz-1:0] r_tx_mem [depth];
  logic [AW-1:0]      r_tx_wptr;
  logic [AW-1:0]      r_tx_rptr;
  logic [CW-1:0]      r_tx_count;
  logic               r_tx_err;

  // ---------------- RX FIFO state ----------------
  logic [pckg_sz-1:0] r_rx_mem [depth];
  logic [AW-1:0]      r_rx_wptr;
  logic [AW-1:0]      r_rx_rptr;
  logic [CW-1:0]      r_rx_count;
  logic               r_rx_ovf;

  logic w_tx_wr;
  logic w_tx_rd;
  logic w_rx_rd;
  logic w_rx_full;
  logic w_addr_ok;
  logic w_rx_wr;
  logic w_rx_lost;

  // Status decoded purely from registered state, so no input reaches an output.
  assign pndng    = (r_tx_count != '0);
  assign tx_ready = (r_tx_count != FULL_CNT);
  assign D_pop    = pndng ? r_tx_mem[r_tx_rptr] : '0;
  assign rx_valid = (r_rx_count != '0);
  assign rx_data  = rx_valid ? r_rx_mem[r_rx_rptr] : '0;
  assign tx_err   = r_tx_err;
  assign rx_ovf   = r_rx_ovf;

  assign w_tx_wr   = tx_valid && tx_ready;
  assign w_tx_rd   = pop && pndng;
  assign w_rx_rd   = rx_valid && rx_ready;
  assign w_rx_full = (r_rx_count == FULL_CNT);

`ifdef BUS_DEV_ADDR_CHECK_EN
  logic [7:0] w_dest;
  logic [7:0] r_drop_cnt;
  assign w_dest      = D_push[pckg_sz-1 -: 8];
  assign w_addr_ok   = (w_dest == 8'(id)) || (w_dest == bdcst);
  assign rx_drop_cnt = r_drop_cnt;

  // Count filtered pushes, holding at 255 instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= 8'd0;
    end else if (push && !w_addr_ok && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end
`else
  assign w_addr_ok   = 1'b1;
  assign rx_drop_cnt = 8'd0;
`endif

  // A same-cycle local pop frees a slot, so a push at full still lands.
  assign w_rx_wr   = push && w_addr_ok && (!w_rx_full || w_rx_rd);
  assign w_rx_lost = push && w_addr_ok && w_rx_full && !w_rx_rd;

  // TX storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && w_tx_wr) begin
      r_tx_mem[r_tx_wptr] <= tx_data;
    end
  end

  // TX pointers, occupancy and the sticky empty-pop error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_count <= '0;
      r_tx_err   <= 1'b0;
    end else begin
      if (w_tx_wr) begin
        r_tx_wptr <= r_tx_wptr + AW'(1);
      end
      if (w_tx_rd) begin
        r_tx_rptr <= r_tx_rptr + AW'(1);
      end
      if (w_tx_wr && !w_tx_rd) begin
        r_tx_count <= r_tx_count + CW'(1);
      end else if (!w_tx_wr && w_tx_rd) begin
        r_tx_count <= r_tx_count - CW'(1);
      end
      if (pop && !pndng) begin
        r_tx_err <= 1'b1;
      end
    end
  end

  // RX storage write.
  always_ff @(posedge clk) begin
    if (!reset && w_rx_wr) begin
      r_rx_mem[r_rx_wptr] <= D_push;
    end
  end

  // RX pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_count <= '0;
      r_rx_ovf   <= 1'b0;
    end else begin
      if (w_rx_wr) begin
        r_rx_wptr <= r_rx_wptr + AW'(1);
      end
      if (w_rx_rd) begin
        r_rx_rptr <= r_rx_rptr + AW'(1);
      end
      if (w_rx_wr && !w_rx_rd) begin
        r_rx_count <= r_rx_count + CW'(1);
      end else if (!w_rx_wr && w_rx_rd) begin
        r_rx_count <= r_rx_count - CW'(1);
      end
      if (w_rx_lost) begin
        r_rx_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_dev_port.sv
// Directed testbench for bus_dev_port (pckg_sz=16, depth=8, id=0).
module tb_bus_dev_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop = 1'b0;
  logic        push = 1'b0;
  logic [15:0] D_push = '0;
  logic        tx_valid = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_ready;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rx_ready = 1'b0;
  logic        tx_err;
  logic        rx_ovf;
  logic [7:0]  rx_drop_cnt;

  int total  = 0;
  int passed = 0;

  bus_dev_port #(.pckg_sz(16), .depth(8), .id(0), .bdcst(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_err(tx_err), .rx_ovf(rx_ovf), .rx_drop_cnt(rx_drop_cnt)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle 1 time unit before driving/sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    // ---- Reset ----
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step();
    reset = 1'b0;
    check("rst_pndng", 32'(pndng), 0);
    check("rst_dpop", 32'(D_pop), 0);
    check("rst_tx_ready", 32'(tx_ready), 1);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_tx_err", 32'(tx_err), 0);
    check("rst_rx_ovf", 32'(rx_ovf), 0);
    check("rst_drop", 32'(rx_drop_cnt), 0);
    $display("reset: done");

    // ---- TX fill ----
    for (int i = 1; i <= 8; i++) begin
      tx_valid = 1'b1;
      tx_data  = 16'h0100 + 16'(i);
      step();
      $display("tx write 0x%04h", tx_data);
      check("fill_head", 32'(D_pop), 32'h0101);
      check("fill_pndng", 32'(pndng), 1);
      check("fill_ready", 32'(tx_ready), (i == 8) ? 1'b0 : 1'b1);
    end
    tx_data = 16'h0109;
    step();
    tx_valid = 1'b0;
    $display("tx write 0x0109 while full");
    check("full_ready", 32'(tx_ready), 0);

    // ---- TX drain ----
    for (int i = 1; i <= 8; i++) begin
      check("drain_dpop", 32'(D_pop), 32'h0100 + 32'(i));
      pop = 1'b1;
      step();
      $display("tx pop #%0d", i);
    end
    pop = 1'b0;
    check("drain_pndng", 32'(pndng), 0);
    check("drain_dpop0", 32'(D_pop), 0);
    check("drain_ready", 32'(tx_ready), 1);
    check("drain_txerr", 32'(tx_err), 0);

    // ---- TX simultaneous write+pop at 3 entries ----
    for (int i = 1; i <= 3; i++) begin
      tx_valid = 1'b1;
      tx_data  = 16'h0200 + 16'(i);
      step();
    end
    tx_data = 16'h0204;
    pop     = 1'b1;
    step();
    tx_valid = 1'b0;
    pop      = 1'b0;
    $display("tx write 0x0204 + pop");
    check("sim_head", 32'(D_pop), 32'h0202);
    for (int i = 2; i <= 4; i++) begin
      check("sim_drain", 32'(D_pop), 32'h0200 + 32'(i));
      pop = 1'b1;
      step();
    end
    check("sim_empty", 32'(pndng), 0);
    check("sim_txerr0", 32'(tx_err), 0);
    step();
    pop = 1'b0;
    $display("tx pop on empty");
    check("err_set", 32'(tx_err), 1);
    check("err_pndng", 32'(pndng), 0);
    step(); step();
    check("err_sticky", 32'(tx_err), 1);

    // ---- RX fill, then push+pop at full ----
    rx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push   = 1'b1;
      D_push = 16'h00C0 + 16'(i);
      step();
      $display("rx push 0x%04h", D_push);
      check("rxf_head", 32'(rx_data), 32'h00C0);
    end
    check("rxf_ovf0", 32'(rx_ovf), 0);
    D_push   = 16'h00B0;
    rx_ready = 1'b1;
    step();
    push = 1'b0;
    $display("rx push 0x00B0 + pop at full");
    check("rxpp_ovf", 32'(rx_ovf), 0);
    check("rxpp_head", 32'(rx_data), 32'h00C1);
    for (int i = 1; i <= 8; i++) begin
      check("rxpp_drain", 32'(rx_data), (i == 8) ? 32'h00B0 : 32'h00C0 + 32'(i));
      step();
    end
    check("rxpp_empty", 32'(rx_valid), 0);
    check("rxpp_data0", 32'(rx_data), 0);

    // ---- RX overflow ----
    rx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push   = 1'b1;
      D_push = 16'h00A0 + 16'(i);
      step();
      $display("rx push 0x%04h", D_push);
      check("ovf_flag", 32'(rx_ovf), (i == 8) ? 1'b1 : 1'b0);
    end
    push     = 1'b0;
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("ovf_drain", 32'(rx_data), 32'h00A0 + 32'(i));
      step();
    end
    check("ovf_empty", 32'(rx_valid), 0);
    check("ovf_sticky", 32'(rx_ovf), 1);

    // ---- Address filter (id=0) ----
    rx_ready = 1'b0;
    push = 1'b1; D_push = 16'h0055; step();
    push = 1'b1; D_push = 16'hFF66; step();
    push = 1'b1; D_push = 16'h0477; step();
    push = 1'b0;
    $display("rx push 0x0055 0xFF66 0x0477");
    rx_ready = 1'b1;
    check("flt_a", 32'(rx_data), 32'h0055);
    step();
    check("flt_b", 32'(rx_data), 32'hFF66);
    step();
`ifdef BUS_DEV_ADDR_CHECK_EN
    check("flt_empty", 32'(rx_valid), 0);
    check("flt_drop", 32'(rx_drop_cnt), 1);
`else
    check("flt_c", 32'(rx_data), 32'h0477);
    step();
    check("flt_empty", 32'(rx_valid), 0);
    check("flt_drop", 32'(rx_drop_cnt), 0);
`endif
    rx_ready = 1'b0;

    // ---- Reset during traffic ----
    tx_valid = 1'b1; tx_data = 16'h0301; step();
    tx_data = 16'h0302; push = 1'b1; D_push = 16'h0099; step();
    check("mid_pndng", 32'(pndng), 1);
    check("mid_rxv", 32'(rx_valid), 1);
    reset = 1'b1; pop = 1'b1; rx_ready = 1'b1;
    step();
    $display("reset during traffic");
    check("rr_pndng", 32'(pndng), 0);
    check("rr_dpop", 32'(D_pop), 0);
    check("rr_ready", 32'(tx_ready), 1);
    check("rr_rxv", 32'(rx_valid), 0);
    check("rr_txerr", 32'(tx_err), 0);
    check("rr_ovf", 32'(rx_ovf), 0);
    step();
    check("rr_hold", 32'(pndng), 0);
    reset = 1'b0; pop = 1'b0; push = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0;
    step();
    check("post_rr_pndng", 32'(pndng), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
